// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop line synchronizer, mid-bit sampling from a clock-count
// timer, registered one-cycle valid / framing-error strobes.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for rxd_s low
// START     | timing half a bit to re-check the start bit at its centre
// DATA      | sampling 8 data bits, LSB first, one per bit period
// STOP      | timing to the centre of the stop bit
// WAIT_IDLE | stop bit was low; hold off until the line returns high
module uart_rx #(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_HZ       = 100000000,
    parameter int CLKS_PER_BIT = CLK_HZ / BIT_RATE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxd,
    output logic [7:0] uart_rx_data,
    output logic       uart_rx_valid,
    output logic       uart_rx_frame_err
);

    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        rxd_m;
    logic        rxd_s;
    logic [15:0] bit_duration;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        half_done;
    logic        bit_done;
    logic        valid_nxt;
    logic        err_nxt;
    logic        sample_en;

    assign half_done = (bit_duration == HALF_M1);
    assign bit_done  = (bit_duration == FULL_M1);

    // Line is idle-high, so the synchronizer resets to 1 to avoid a false start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= uart_rxd;
            rxd_s <= rxd_m;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (!rxd_s) state_nxt = START;
            end
            START: begin
                if (half_done) state_nxt = rxd_s ? IDLE : DATA;
            end
            DATA: begin
                if (bit_done && (bit_idx == 3'd7)) state_nxt = STOP;
            end
            STOP: begin
                if (bit_done) state_nxt = rxd_s ? IDLE : WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (rxd_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;
        sample_en = 1'b0;
        unique case (state)
            DATA: begin
                sample_en = bit_done;
            end
            STOP: begin
                valid_nxt = bit_done && rxd_s;
                err_nxt   = bit_done && !rxd_s;
            end
            default: begin
                valid_nxt = 1'b0;
                err_nxt   = 1'b0;
                sample_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_duration <= 16'd0;
        end else begin
            unique case (state)
                START:     bit_duration <= half_done ? 16'd0 : bit_duration + 16'd1;
                DATA,
                STOP:      bit_duration <= bit_done ? 16'd0 : bit_duration + 16'd1;
                default:   bit_duration <= 16'd0;
            endcase
        end
    end

    // bit_idx wraps 7 -> 0 on the last data bit, ready for the next frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_idx <= 3'd0;
            shift   <= 8'h00;
        end else begin
            if ((state == START) && half_done) begin
                bit_idx <= 3'd0;
            end else if (sample_en) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (sample_en) begin
                shift[bit_idx] <= rxd_s;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            uart_rx_data      <= 8'h00;
            uart_rx_valid     <= 1'b0;
            uart_rx_frame_err <= 1'b0;
        end else begin
            uart_rx_valid     <= valid_nxt;
            uart_rx_frame_err <= err_nxt;
            if (valid_nxt) begin
                uart_rx_data <= shift;
            end
        end
    end

endmodule
